// File: rtl/i2c_log_pkg.sv
// Shared types and constants for the I2C capture logger.
// Entries are {type, value}; header byte on the wire is HDR_BASE | type.
package i2c_log_pkg;

  localparam int ENTRY_W = 10;

  localparam logic [1:0] TYPE_ADDR = 2'd0;
  localparam logic [1:0] TYPE_REG  = 2'd1;
  localparam logic [1:0] TYPE_DATA = 2'd2;

  localparam logic [7:0] HDR_BASE = 8'hA0;

  typedef struct packed {
    logic [1:0] typ;
    logic [7:0] val;
  } entry_t;

  typedef enum logic [1:0] {SEQ_IDLE, SEQ_HDR, SEQ_VAL} seq_state_e;

  typedef enum logic [1:0] {SER_IDLE, SER_START, SER_DATA, SER_STOP} ser_state_e;

  function automatic logic [7:0] hdr_byte(input logic [1:0] typ);
    return HDR_BASE | {6'd0, typ};
  endfunction

endpackage

// File: rtl/uart_tx_8n1.sv
// 8N1 bit serializer; start accepted only while idle (ready high).
// tx is a register with async set so reset forces the line idle at once.
module uart_tx_8n1
  import i2c_log_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data,
  input  logic       start,
  output logic       tx,
  output logic       ready
);

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] RELOAD      = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] RELOAD_STOP = CW'(CLKS_PER_BIT - 2);

  ser_state_e    state_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    bit_q;
  logic [7:0]    shift_q;
  logic          tx_q;

  // The stop bit spends its last cycle in IDLE with tx high, so a start
  // accepted there follows the stop bit with no idle gap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= SER_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      case (state_q)
        SER_IDLE: begin
          tx_q <= 1'b1;
          if (start) begin
            state_q <= SER_START;
            cnt_q   <= RELOAD;
            shift_q <= data;
            tx_q    <= 1'b0;
          end
        end
        SER_START: begin
          if (cnt_q == '0) begin
            state_q <= SER_DATA;
            cnt_q   <= RELOAD;
            bit_q   <= '0;
            tx_q    <= shift_q[0];
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        SER_DATA: begin
          if (cnt_q == '0) begin
            if (bit_q == 3'd7) begin
              state_q <= SER_STOP;
              cnt_q   <= RELOAD_STOP;
              tx_q    <= 1'b1;
            end else begin
              bit_q   <= bit_q + 1'b1;
              cnt_q   <= RELOAD;
              shift_q <= shift_q >> 1;
              tx_q    <= shift_q[1];
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: begin
          tx_q <= 1'b1;
          if (cnt_q == '0) state_q <= SER_IDLE;
          else             cnt_q   <= cnt_q - 1'b1;
        end
      endcase
    end
  end

  assign tx    = tx_q;
  assign ready = (state_q == SER_IDLE);

endmodule

// File: rtl/i2c_log_uart.sv
// Logs sniffed I2C capture pulses as tagged 2-byte UART records via a FIFO.
// One event written per cycle; lost or rejected events are counted, sticky overflow.
module i2c_log_uart
  import i2c_log_pkg::*;
#(
  parameter int CLK_HZ     = 100_000_000,
  parameter int BAUD       = 115_200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    address,
  input  logic                          address_ready,
  input  logic [7:0]                    reg_address,
  input  logic                          reg_address_ready,
  input  logic [7:0]                    reg_data,
  input  logic                          reg_data_ready,
  output logic                          uart_tx,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  output logic [15:0]                   drop_count,
  output logic                          busy
);

  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  entry_t      mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LW-1:0] level_q, level_d;
  logic        ovf_q;
  logic [15:0] drop_q, drop_d;
  seq_state_e  seq_q;
  logic [7:0]  val_q;

  logic        wr_req, wr_ok, rejected, pop, full;
  entry_t      wr_ent, head;
  logic [1:0]  n_pulse, lost, drop_inc;
  logic [16:0] drop_sum;
  logic        ser_start, ser_ready, ser_tx;
  logic [7:0]  ser_data;

  assign head = mem_q[rd_ptr_q];
  assign full = (level_q == LW'(FIFO_DEPTH));
  assign pop  = (seq_q == SEQ_IDLE) && (level_q != '0) && ser_ready;

  always_comb begin
    wr_req  = address_ready | reg_address_ready | reg_data_ready;
    n_pulse = {1'b0, address_ready} + {1'b0, reg_address_ready} + {1'b0, reg_data_ready};
    if (address_ready)          wr_ent = '{typ: TYPE_ADDR, val: address};
    else if (reg_address_ready) wr_ent = '{typ: TYPE_REG,  val: reg_address};
    else                        wr_ent = '{typ: TYPE_DATA, val: reg_data};
    // A pop in the same cycle frees a slot, so a full FIFO still accepts.
    wr_ok    = wr_req && (!full || pop);
    rejected = wr_req && !wr_ok;
    lost     = wr_req ? (n_pulse - 2'd1) : 2'd0;
    drop_inc = lost + {1'b0, rejected};
    drop_sum = {1'b0, drop_q} + {15'd0, drop_inc};
    drop_d   = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    level_d  = level_q + LW'(wr_ok) - LW'(pop);
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wr_ptr_q] <= wr_ent;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
      drop_q   <= '0;
    end else begin
      if (wr_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)   rd_ptr_q <= rd_ptr_q + 1'b1;
      level_q <= level_d;
      drop_q  <= drop_d;
      if (drop_inc != 2'd0) ovf_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seq_q <= SEQ_IDLE;
      val_q <= '0;
    end else begin
      case (seq_q)
        SEQ_IDLE: if (pop) begin
          seq_q <= SEQ_HDR;
          val_q <= head.val;
        end
        SEQ_HDR:  if (ser_ready) seq_q <= SEQ_VAL;
        default:  if (ser_ready) seq_q <= SEQ_IDLE;
      endcase
    end
  end

  assign ser_start = pop || ((seq_q == SEQ_HDR) && ser_ready);
  assign ser_data  = pop ? hdr_byte(head.typ) : val_q;

  uart_tx_8n1 #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_ser (
    .clk   (clk),
    .rst   (rst),
    .data  (ser_data),
    .start (ser_start),
    .tx    (ser_tx),
    .ready (ser_ready)
  );

  assign uart_tx    = ser_tx;
  assign fifo_level = level_q;
  assign overflow   = ovf_q;
  assign drop_count = drop_q;
  assign busy       = (level_q != '0) || (seq_q != SEQ_IDLE) || !ser_ready;

endmodule

// File: tb/tb_i2c_log_uart.sv
// Bench for i2c_log_uart: queue-based record model checked every cycle,
// a UART line decoder, and directed scenarios with literal expectations.
module tb_i2c_log_uart;

  localparam int CPB   = 10;
  localparam int DEPTH = 4;
  localparam int REC   = 20 * CPB;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] address = 8'h00, reg_address = 8'h00, reg_data = 8'h00;
  logic       address_ready = 1'b0, reg_address_ready = 1'b0, reg_data_ready = 1'b0;
  logic       uart_tx;
  logic [2:0] fifo_level;
  logic       overflow;
  logic [15:0] drop_count;
  logic       busy;

  always #5 clk = ~clk;

  i2c_log_uart #(.CLK_HZ(1000), .BAUD(100), .FIFO_DEPTH(DEPTH)) dut (
    .clk               (clk),
    .rst               (rst),
    .address           (address),
    .address_ready     (address_ready),
    .reg_address       (reg_address),
    .reg_address_ready (reg_address_ready),
    .reg_data          (reg_data),
    .reg_data_ready    (reg_data_ready),
    .uart_tx           (uart_tx),
    .fifo_level        (fifo_level),
    .overflow          (overflow),
    .drop_count        (drop_count),
    .busy              (busy)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int peak    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: queue of stored entries plus the position inside the record on the wire.
  logic [9:0] mq[$];
  int         rec_t  = -1;
  logic [1:0] m_typ  = 2'd0;
  logic [7:0] m_val  = 8'h00;
  int         m_drop = 0;
  bit         m_ovf  = 1'b0;

  always @(posedge clk or posedge rst) begin : model_step
    int np, inc;
    bit pop, acc;
    logic [9:0] ent;
    if (rst) begin
      mq.delete();
      rec_t  = -1;
      m_drop = 0;
      m_ovf  = 1'b0;
    end else begin
      np = 0;
      if (address_ready)     np++;
      if (reg_address_ready) np++;
      if (reg_data_ready)    np++;
      pop = (rec_t < 0) && (mq.size() > 0);
      acc = (np > 0) && ((mq.size() < DEPTH) || pop);
      if (address_ready)          ent = {2'd0, address};
      else if (reg_address_ready) ent = {2'd1, reg_address};
      else                        ent = {2'd2, reg_data};
      inc = (np > 0) ? (np - 1) : 0;
      if (np > 0 && !acc) inc++;
      if (inc > 0) m_ovf = 1'b1;
      m_drop = (m_drop + inc > 65535) ? 65535 : m_drop + inc;
      if (pop) begin
        {m_typ, m_val} = mq.pop_front();
        rec_t = 0;
      end else if (rec_t >= 0) begin
        rec_t++;
        if (rec_t == REC) rec_t = -1;
      end
      if (acc) mq.push_back(ent);
    end
  end

  function automatic logic exp_tx(input int t, input logic [1:0] typ, input logic [7:0] val);
    int b, k;
    logic [7:0] by;
    if (t < 0) return 1'b1;
    b  = t / CPB;
    by = (b < 10) ? (8'hA0 + {6'd0, typ}) : val;
    k  = b % 10;
    if (k == 0) return 1'b0;
    if (k == 9) return 1'b1;
    return by[k-1];
  endfunction

  always @(negedge clk) begin
    check("tx", {31'd0, uart_tx}, {31'd0, exp_tx(rec_t, m_typ, m_val)});
    check("level", {29'd0, fifo_level}, mq.size());
    check("overflow", {31'd0, overflow}, {31'd0, m_ovf});
    check("drop_count", {16'd0, drop_count}, m_drop);
    check("busy", {31'd0, busy}, {31'd0, (mq.size() > 0) || (rec_t >= 0)});
    if (int'(fifo_level) > peak) peak = int'(fifo_level);
  end

  // Line decoder: samples mid-bit after each detected start-bit fall.
  logic [7:0] rx_q[$];
  int         fall_q[$];
  int         d_state = 0, d_cnt = 0, frame_err = 0;
  logic [7:0] d_sh = 8'h00;

  always @(negedge clk or posedge rst) begin : decoder
    int k;
    if (rst) begin
      d_state = 0;
    end else if (d_state == 0) begin
      if (uart_tx === 1'b0) begin
        d_state = 1;
        d_cnt   = 0;
        fall_q.push_back(cyc);
      end
    end else begin
      d_cnt++;
      if (d_cnt % CPB == CPB / 2) begin
        k = d_cnt / CPB;
        if (k >= 1 && k <= 8) d_sh[k-1] = uart_tx;
        else if (k == 9) begin
          if (uart_tx !== 1'b1) frame_err++;
          rx_q.push_back(d_sh);
          d_state = 0;
        end
      end
    end
  end

  function automatic logic [7:0] rx_at(input int i);
    if (i < rx_q.size()) return rx_q[i];
    return 8'hxx;
  endfunction

  function automatic int fall_at(input int i);
    if (i < fall_q.size()) return fall_q[i];
    return -1000;
  endfunction

  task automatic pulse(input bit a, input bit r, input bit d,
                       input logic [7:0] av, input logic [7:0] rv, input logic [7:0] dv,
                       output int at);
    @(posedge clk); #1;
    address = av; reg_address = rv; reg_data = dv;
    address_ready = a; reg_address_ready = r; reg_data_ready = d;
    at = cyc;
    @(posedge clk); #1;
    address_ready = 1'b0; reg_address_ready = 1'b0; reg_data_ready = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output int when);
    int k;
    k = 0;
    when = -1;
    while (k < budget) begin
      @(negedge clk);
      if (busy === 1'b0) begin
        when = cyc;
        break;
      end
      k++;
    end
    check("idle_reached", {31'd0, busy}, 32'd0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    rx_q.delete();
    fall_q.delete();
    peak = 0;
  endtask

  task automatic check_stream(input string name, input logic [7:0] exp[$]);
    check({name, "_count"}, rx_q.size(), exp.size());
    foreach (exp[i]) check($sformatf("%s_byte%0d", name, i), {24'd0, rx_at(i)}, {24'd0, exp[i]});
  endtask

  initial begin
    int n, t_idle, dummy;
    logic [7:0] e[$];
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset values
    @(negedge clk);
    check("rst_tx", {31'd0, uart_tx}, 32'd1);
    check("rst_level", {29'd0, fifo_level}, 32'd0);
    check("rst_ovf", {31'd0, overflow}, 32'd0);
    check("rst_drop", {16'd0, drop_count}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);

    // Single address pulse
    rx_q.delete(); fall_q.delete();
    pulse(1, 0, 0, 8'h50, 8'h00, 8'h00, n);
    wait_idle(400, t_idle);
    e = '{8'hA0, 8'h50};
    check_stream("single", e);
    check("single_fall_lat", fall_at(0) - n, 32'd2);
    check("single_frame_len", t_idle - fall_at(0), 32'd200);

    // Write transaction, pulses 3 cycles apart
    rx_q.delete(); fall_q.delete();
    pulse(1, 0, 0, 8'hA0, 8'h00, 8'h00, n);
    @(posedge clk);
    pulse(0, 1, 0, 8'h00, 8'h10, 8'h00, dummy);
    @(posedge clk);
    pulse(0, 0, 1, 8'h00, 8'h00, 8'h5A, dummy);
    wait_idle(1000, t_idle);
    e = '{8'hA0, 8'hA0, 8'hA1, 8'h10, 8'hA2, 8'h5A};
    check_stream("wr_txn", e);
    check("wr_txn_drop", {16'd0, drop_count}, 32'd0);

    // Six events back to back: sixth hits a full FIFO
    rx_q.delete(); fall_q.delete(); peak = 0;
    pulse(1, 0, 0, 8'h11, 8'h00, 8'h00, n);
    pulse(0, 1, 0, 8'h00, 8'h22, 8'h00, dummy);
    pulse(0, 0, 1, 8'h00, 8'h00, 8'h33, dummy);
    pulse(1, 0, 0, 8'h44, 8'h00, 8'h00, dummy);
    pulse(0, 1, 0, 8'h00, 8'h55, 8'h00, dummy);
    pulse(0, 0, 1, 8'h00, 8'h00, 8'h66, dummy);
    wait_idle(1500, t_idle);
    e = '{8'hA0, 8'h11, 8'hA1, 8'h22, 8'hA2, 8'h33, 8'hA0, 8'h44, 8'hA1, 8'h55};
    check_stream("burst", e);
    check("burst_ovf", {31'd0, overflow}, 32'd1);
    check("burst_drop", {16'd0, drop_count}, 32'd1);
    check("burst_peak", peak, 32'd4);

    // Simultaneous address and data pulses
    do_reset();
    pulse(1, 0, 1, 8'h3C, 8'h00, 8'h99, n);
    wait_idle(400, t_idle);
    e = '{8'hA0, 8'h3C};
    check_stream("collide", e);
    check("collide_drop", {16'd0, drop_count}, 32'd1);
    check("collide_ovf", {31'd0, overflow}, 32'd1);

    // Reset in the middle of the header data bits, with entries still queued
    do_reset();
    pulse(1, 0, 0, 8'h77, 8'h00, 8'h00, n);
    pulse(0, 1, 0, 8'h00, 8'h88, 8'h00, dummy);
    pulse(0, 0, 1, 8'h00, 8'h00, 8'h99, dummy);
    repeat (35) @(negedge clk);
    check("mid_pre_tx_low_possible_level", {29'd0, fifo_level}, 32'd2);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_tx", {31'd0, uart_tx}, 32'd1);
    check("mid_rst_level", {29'd0, fifo_level}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    rx_q.delete(); fall_q.delete();
    pulse(1, 0, 0, 8'h12, 8'h00, 8'h00, n);
    wait_idle(400, t_idle);
    e = '{8'hA0, 8'h12};
    check_stream("post_rst", e);
    check("post_rst_drop", {16'd0, drop_count}, 32'd0);

    // Saturation: all three pulses every cycle for 25000 cycles
    do_reset();
    @(posedge clk); #1;
    address = 8'hC3; reg_address = 8'h3C; reg_data = 8'h5A;
    address_ready = 1'b1; reg_address_ready = 1'b1; reg_data_ready = 1'b1;
    repeat (25000) @(posedge clk);
    #1;
    address_ready = 1'b0; reg_address_ready = 1'b0; reg_data_ready = 1'b0;
    @(negedge clk);
    check("sat_drop", {16'd0, drop_count}, 32'h0000FFFF);
    check("sat_ovf", {31'd0, overflow}, 32'd1);
    do_reset();
    @(negedge clk);
    check("sat_rst_drop", {16'd0, drop_count}, 32'd0);
    check("frame_err", frame_err, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/i2c_log_uart.md
# i2c_log_uart

Downstream consumer of the passive I2C sniffer's capture outputs. Turns each single-cycle capture pulse (device address, register address, data byte) into a tagged 2-byte record. Records are buffered in a small FIFO and streamed out as 8N1 UART, so sniffed bus traffic can be logged on a host PC. The block never touches the I2C bus.

## Interface
Parameters:
- CLK_HZ, 100_000_000, system clock frequency.
- BAUD, 115_200, UART bit rate. CLKS_PER_BIT = CLK_HZ/BAUD, integer-truncated, must be ≥ 4.
- FIFO_DEPTH, 16, record entries; power of two, ≥ 2.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- address  in  8  captured device address byte (R/W in bit 0).
- address_ready  in  1  one-cycle pulse; address valid.
- reg_address  in  8  captured register address.
- reg_address_ready  in  1  one-cycle pulse.
- reg_data  in  8  captured data byte (write or read).
- reg_data_ready  in  1  one-cycle pulse.
- uart_tx  out  1  serial output; idle high.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  entries currently stored.
- overflow  out  1  sticky; set on the first dropped event.
- drop_count  out  16  dropped events; saturates at 0xFFFF.
- busy  out  1  high while the FIFO is non-empty or the serializer is not idle.

## Operation
- Event capture: each cycle, at most one event is written.
  - Priority: address_ready > reg_address_ready > reg_data_ready.
  - Any lower-priority pulse in the same cycle is lost: drop_count increments by 1 per lost pulse, and overflow is set.
- Entry format: 10 bits, {type[1:0], value[7:0]}.
  - type 0 = address, 1 = reg_address, 2 = data.
- Full FIFO: a write is rejected when fifo_level == FIFO_DEPTH, unless a pop happens in the same cycle; in that case the write is accepted and the level is unchanged.
  - Each rejected write increments drop_count and sets overflow.
- Record output, two UART bytes per entry:
  - Header byte: 0xA0 | type, giving 0xA0, 0xA1 or 0xA2.
  - Then the value byte.
- Frame format: start bit 0, 8 data bits LSB first, stop bit 1. Header and value are sent back-to-back with no idle gap.
- Sequencer states:
  - IDLE → HDR when the FIFO is non-empty; the entry is popped on this transition.
  - HDR → VAL at the end of the header's stop bit.
  - VAL → IDLE at the end of the value's stop bit.
- Bit serializer states: IDLE, START, DATA (bit index 0..7), STOP. Each bit lasts exactly CLKS_PER_BIT cycles, counted by a down-counter reloaded at each bit boundary.
- overflow and drop_count are cleared only by rst.

## Timing
- Reset values: uart_tx = 1, fifo_level = 0, overflow = 0, drop_count = 0, busy = 0. Sequencer and serializer return to IDLE.
- Reset mid-frame: uart_tx goes high immediately (asynchronously) and the FIFO is emptied. No partial byte is resumed.
- Write latency: a pulse in cycle N is stored at the cycle N clock edge. fifo_level reflects it in cycle N+1.
- Pop latency: the pop occurs in the first cycle with the sequencer in IDLE and the FIFO non-empty. uart_tx drives the start bit from the next cycle.
- Record duration: exactly 20 × CLKS_PER_BIT cycles from header start-bit falling edge to the end of the value stop bit.
- Next record: if the FIFO is non-empty at that point, the next pop happens on the first cycle after the value stop bit ends. The next start bit follows 1 cycle later (1-cycle idle gap).
- busy falls in the cycle after the final stop bit completes with the FIFO empty.
- FIFO pointers wrap modulo FIFO_DEPTH. fifo_level uses one extra bit so that full and empty are distinct.

## Structure
- Package i2c_log_pkg:
  - type codes TYPE_ADDR = 2'd0, TYPE_REG = 2'd1, TYPE_DATA = 2'd2;
  - HDR_BASE = 8'hA0;
  - the entry width constant (10).
- Sub-module uart_tx_8n1 (CLKS_PER_BIT parameter):
  - inputs: data[7:0], start;
  - outputs: tx, ready;
  - `ready` is high only in serializer IDLE;
  - start is accepted only when ready.
- The top level holds the event priority encoder, the FIFO (register array), the HDR/VAL sequencer and the drop accounting.

## Test plan
All cases use CLK_HZ = 1000, BAUD = 100 (CLKS_PER_BIT = 10) and FIFO_DEPTH = 4.
- Single address pulse with address = 0x50 → uart_tx decodes bytes 0xA0, 0x50. Start-bit fall occurs 2 cycles after the pulse; frame lasts 200 cycles; busy is then 0.
- Write transaction: address = 0xA0, then reg_address = 0x10, then reg_data = 0x5A, pulses 3 cycles apart → byte stream 0xA0 0xA0 0xA1 0x10 0xA2 0x5A. drop_count = 0.
- Six events within 20 cycles → first 5 transmitted (1 popped + 4 buffered). Sixth dropped: overflow = 1, drop_count = 1, fifo_level peaks at 4.
- address_ready and reg_data_ready pulsed in the same cycle → only the address record is sent; drop_count = 1.
- rst asserted in the middle of the header's data bits → uart_tx = 1 immediately, fifo_level = 0, counters 0. After release, a new event transmits cleanly.
- 70000 rejected writes with uart output stalled by a full FIFO (forced) → drop_count saturates at 0xFFFF.
